// File: rtl/seven_segment_scan_if.sv
// Display-side bus for the 7-segment scan controller.
//   data_in/dp_in/digit_en/load : producer -> controller (display values + capture strobe)
//   load_ack/frame_start        : controller -> producer (apply / frame pulses)
//   s_a..s_g/dp/anode           : controller -> display pins (all active-low)
interface seven_segment_scan_if;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic [7:0]  digit_en;
    logic        load;
    logic        load_ack;
    logic        frame_start;
    logic        s_a;
    logic        s_b;
    logic        s_c;
    logic        s_d;
    logic        s_e;
    logic        s_f;
    logic        s_g;
    logic        dp;
    logic [7:0]  anode;

    modport master (
        output data_in, dp_in, digit_en, load,
        input  load_ack, frame_start, s_a, s_b, s_c, s_d, s_e, s_f, s_g, dp, anode
    );

    modport slave (
        input  data_in, dp_in, digit_en, load,
        output load_ack, frame_start, s_a, s_b, s_c, s_d, s_e, s_f, s_g, dp, anode
    );
endinterface

// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Steps one digit at a time (DISPLAY), with an all-dark BLANK gap between digits.
// New display values are captured into pending registers on load and only
// become active at the start of a frame, so a frame never mixes old and new data.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seven_segment_scan_if.slave (inputs, handshake pulses, display pins)
module seven_segment_scan_controller #(
    parameter int unsigned NUM_DIGITS      = 8,
    parameter int unsigned TICKS_PER_DIGIT = 100000,
    parameter int unsigned BLANK_TICKS     = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_segment_scan_if.slave  bus
);

    localparam int unsigned CNT_MAX = (TICKS_PER_DIGIT > BLANK_TICKS) ? TICKS_PER_DIGIT : BLANK_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned IDX_W   = 3;

    localparam logic [CNT_W-1:0] DISP_LAST  = CNT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK   = 1'b0,
        ST_DISPLAY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             first_q, first_d;

    logic [31:0]      act_data_q, act_data_d;
    logic [7:0]       act_dp_q, act_dp_d;
    logic [7:0]       act_en_q, act_en_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic [7:0]       pend_dp_q, pend_dp_d;
    logic [7:0]       pend_en_q, pend_en_d;
    logic             pend_valid_q, pend_valid_d;

    logic [7:0]       anode_q, anode_d;
    logic [6:0]       segs_q, segs_d;
    logic             dp_q, dp_d;
    logic             load_ack_q, load_ack_d;
    logic             frame_start_q, frame_start_d;

    logic             enter_disp;
    logic [3:0]       nib;

    // Active-low {a,b,c,d,e,f,g} pattern for a hex nibble
    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b0000001;
            4'h1: s = 7'b1001111;
            4'h2: s = 7'b0010010;
            4'h3: s = 7'b0000110;
            4'h4: s = 7'b1001100;
            4'h5: s = 7'b0100100;
            4'h6: s = 7'b0100000;
            4'h7: s = 7'b0001111;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0000100;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b1100000;
            4'hC: s = 7'b0110001;
            4'hD: s = 7'b1000010;
            4'hE: s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    // Next-state, load handshake and registered-output computation
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q + CNT_W'(1);
        first_d       = first_q;
        act_data_d    = act_data_q;
        act_dp_d      = act_dp_q;
        act_en_d      = act_en_q;
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_en_d     = pend_en_q;
        pend_valid_d  = pend_valid_q;
        load_ack_d    = 1'b0;
        frame_start_d = 1'b0;
        enter_disp    = 1'b0;
        anode_d       = 8'hFF;
        segs_d        = 7'h7F;
        dp_d          = 1'b1;
        nib           = 4'h0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d    = ST_DISPLAY;
                    cnt_d      = '0;
                    enter_disp = 1'b1;
                    first_d    = 1'b0;
                    // The first gap after reset targets digit 0 rather than advancing
                    if (first_q || (idx_q == IDX_LAST)) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_DISPLAY: begin
                if (cnt_q == DISP_LAST) begin
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        endcase

        // Frame boundary: apply whatever was pending before this edge
        if (enter_disp && (idx_d == '0)) begin
            frame_start_d = 1'b1;
            if (pend_valid_q) begin
                act_data_d   = pend_data_q;
                act_dp_d     = pend_dp_q;
                act_en_d     = pend_en_q;
                pend_valid_d = 1'b0;
                load_ack_d   = 1'b1;
            end
        end

        // A capture on the apply edge stays pending for the following frame
        if (bus.load) begin
            pend_data_d  = bus.data_in;
            pend_dp_d    = bus.dp_in;
            pend_en_d    = bus.digit_en;
            pend_valid_d = 1'b1;
        end

        nib = act_data_d[{idx_d, 2'b00} +: 4];
        if ((state_d == ST_DISPLAY) && act_en_d[idx_d]) begin
            anode_d[idx_d] = 1'b0;
            segs_d         = hex7(nib);
            dp_d           = ~act_dp_d[idx_d];
        end
    end

    // State, data and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            idx_q         <= '0;
            cnt_q         <= '0;
            first_q       <= 1'b1;
            act_data_q    <= '0;
            act_dp_q      <= '0;
            act_en_q      <= '0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_en_q     <= '0;
            pend_valid_q  <= 1'b0;
            anode_q       <= 8'hFF;
            segs_q        <= 7'h7F;
            dp_q          <= 1'b1;
            load_ack_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            first_q       <= first_d;
            act_data_q    <= act_data_d;
            act_dp_q      <= act_dp_d;
            act_en_q      <= act_en_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_en_q     <= pend_en_d;
            pend_valid_q  <= pend_valid_d;
            anode_q       <= anode_d;
            segs_q        <= segs_d;
            dp_q          <= dp_d;
            load_ack_q    <= load_ack_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.anode       = anode_q;
    assign bus.s_a         = segs_q[6];
    assign bus.s_b         = segs_q[5];
    assign bus.s_c         = segs_q[4];
    assign bus.s_d         = segs_q[3];
    assign bus.s_e         = segs_q[2];
    assign bus.s_f         = segs_q[1];
    assign bus.s_g         = segs_q[0];
    assign bus.dp          = dp_q;
    assign bus.load_ack    = load_ack_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Directed bench for seven_segment_scan_controller (TICKS_PER_DIGIT=4, BLANK_TICKS=2).
// Two instances: 8 digits (u_dut) and 4 digits (u_dut4). Outputs sampled on negedge.
module tb_seven_segment_scan_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst4_n;

    seven_segment_scan_if u_if ();
    seven_segment_scan_if u_if4 ();

    seven_segment_scan_controller #(
        .NUM_DIGITS(8), .TICKS_PER_DIGIT(4), .BLANK_TICKS(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(u_if)
    );

    seven_segment_scan_controller #(
        .NUM_DIGITS(4), .TICKS_PER_DIGIT(4), .BLANK_TICKS(2)
    ) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(u_if4)
    );

    logic [6:0] segs8;
    logic [6:0] segs4;
    assign segs8 = {u_if.s_a, u_if.s_b, u_if.s_c, u_if.s_d, u_if.s_e, u_if.s_f, u_if.s_g};
    assign segs4 = {u_if4.s_a, u_if4.s_b, u_if4.s_c, u_if4.s_d, u_if4.s_e, u_if4.s_f, u_if4.s_g};

    // Hand-entered active-low {a..g} decode table
    logic [6:0] hex_tab [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int tests = 0;
    int fails = 0;

    task automatic wait_fs8(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (u_if.frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fs4(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (u_if4.frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst4_n = 1'b0;
        u_if.data_in = '0; u_if.dp_in = '0; u_if.digit_en = '0; u_if.load = 1'b0;
        u_if4.data_in = '0; u_if4.dp_in = '0; u_if4.digit_en = '0; u_if4.load = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (u_if.anode !== 8'hFF) begin fails++; $display("FAIL reset_anode got %h exp ff", u_if.anode); end
        tests++; if (segs8 !== 7'h7F) begin fails++; $display("FAIL reset_segs got %b exp 1111111", segs8); end
        tests++; if (u_if.dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b exp 1", u_if.dp); end
        tests++; if (u_if.load_ack !== 1'b0) begin fails++; $display("FAIL reset_load_ack got %b exp 0", u_if.load_ack); end
        tests++; if (u_if.frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start got %b exp 0", u_if.frame_start); end
        tests++; if (u_if4.anode !== 8'hFF) begin fails++; $display("FAIL reset_anode4 got %h exp ff", u_if4.anode); end
    endtask

    task automatic test_post_reset();
        rst_n = 1'b1; rst4_n = 1'b1;
        @(negedge clk);
        tests++; if (u_if.frame_start !== 1'b0) begin fails++; $display("FAIL post_reset_blank_fs got %b exp 0", u_if.frame_start); end
        tests++; if (u_if.anode !== 8'hFF) begin fails++; $display("FAIL post_reset_blank_anode got %h exp ff", u_if.anode); end
        @(negedge clk);
        tests++; if (u_if.frame_start !== 1'b1) begin fails++; $display("FAIL post_reset_fs got %b exp 1", u_if.frame_start); end
        tests++; if (u_if.anode !== 8'hFF) begin fails++; $display("FAIL post_reset_dark got %h exp ff", u_if.anode); end
        tests++; if (u_if.load_ack !== 1'b0) begin fails++; $display("FAIL post_reset_ack got %b exp 0", u_if.load_ack); end
    endtask

    task automatic test_load_basic();
        bit ok;
        wait_fs8(ok);
        tests++; if (!ok) begin fails++; $display("FAIL load_basic_wait0 timeout"); end
        u_if.data_in = 32'h0123_4567; u_if.dp_in = 8'h01; u_if.digit_en = 8'hFF; u_if.load = 1'b1;
        @(negedge clk);
        u_if.load = 1'b0;
        wait_fs8(ok);
        tests++; if (!ok) begin fails++; $display("FAIL load_basic_wait1 timeout"); end
        tests++; if (u_if.load_ack !== 1'b1) begin fails++; $display("FAIL load_basic_ack got %b exp 1", u_if.load_ack); end
        tests++; if (u_if.anode !== 8'hFE) begin fails++; $display("FAIL load_basic_anode0 got %h exp fe", u_if.anode); end
        tests++; if (segs8 !== 7'b0001111) begin fails++; $display("FAIL load_basic_segs0 got %b exp 0001111", segs8); end
        tests++; if (u_if.dp !== 1'b0) begin fails++; $display("FAIL load_basic_dp0 got %b exp 0", u_if.dp); end
        @(negedge clk);
        tests++; if (u_if.load_ack !== 1'b0) begin fails++; $display("FAIL load_basic_ack_pulse got %b exp 0", u_if.load_ack); end
        repeat (41) @(negedge clk);
        tests++; if (u_if.anode !== 8'h7F) begin fails++; $display("FAIL load_basic_anode7 got %h exp 7f", u_if.anode); end
        tests++; if (segs8 !== 7'b0000001) begin fails++; $display("FAIL load_basic_segs7 got %b exp 0000001", segs8); end
        tests++; if (u_if.dp !== 1'b1) begin fails++; $display("FAIL load_basic_dp7 got %b exp 1", u_if.dp); end
    endtask

    task automatic test_timing();
        bit ok;
        logic [31:0] d;
        logic [7:0] exp_an;
        logic [6:0] exp_sg;
        logic exp_dp;
        d = 32'h0123_4567;
        wait_fs8(ok);
        tests++; if (!ok) begin fails++; $display("FAIL timing_wait timeout"); end
        for (int off = 0; off < 48; off++) begin
            int k;
            k = off / 6;
            exp_an = 8'hFF; exp_sg = 7'h7F; exp_dp = 1'b1;
            if ((off % 6) < 4) begin
                exp_an[k] = 1'b0;
                exp_sg = hex_tab[d[k*4 +: 4]];
                exp_dp = (k == 0) ? 1'b0 : 1'b1;
            end
            tests++; if (u_if.anode !== exp_an) begin fails++; $display("FAIL timing_anode off=%0d got %h exp %h", off, u_if.anode, exp_an); end
            tests++; if (segs8 !== exp_sg) begin fails++; $display("FAIL timing_segs off=%0d got %b exp %b", off, segs8, exp_sg); end
            tests++; if (u_if.dp !== exp_dp) begin fails++; $display("FAIL timing_dp off=%0d got %b exp %b", off, u_if.dp, exp_dp); end
            tests++; if (u_if.frame_start !== (off == 0)) begin fails++; $display("FAIL timing_fs off=%0d got %b exp %b", off, u_if.frame_start, (off == 0)); end
            @(negedge clk);
        end
        tests++; if (u_if.frame_start !== 1'b1) begin fails++; $display("FAIL timing_period got %b exp 1", u_if.frame_start); end
    endtask

    task automatic test_enable();
        bit ok;
        logic [31:0] d;
        logic [7:0] en;
        logic [7:0] exp_an;
        logic [6:0] exp_sg;
        d = 32'h0123_4567;
        en = 8'b1010_1010;
        u_if.digit_en = en; u_if.load = 1'b1;
        @(negedge clk);
        u_if.load = 1'b0;
        wait_fs8(ok);
        tests++; if (!ok) begin fails++; $display("FAIL enable_wait timeout"); end
        tests++; if (u_if.load_ack !== 1'b1) begin fails++; $display("FAIL enable_ack got %b exp 1", u_if.load_ack); end
        for (int off = 0; off < 48; off++) begin
            int k;
            k = off / 6;
            exp_an = 8'hFF; exp_sg = 7'h7F;
            if (((off % 6) < 4) && en[k]) begin
                exp_an[k] = 1'b0;
                exp_sg = hex_tab[d[k*4 +: 4]];
            end
            tests++; if (u_if.anode !== exp_an) begin fails++; $display("FAIL enable_anode off=%0d got %h exp %h", off, u_if.anode, exp_an); end
            tests++; if (segs8 !== exp_sg) begin fails++; $display("FAIL enable_segs off=%0d got %b exp %b", off, segs8, exp_sg); end
            @(negedge clk);
        end
    endtask

    task automatic test_pending();
        bit ok;
        int acks;
        logic [31:0] d;
        logic [7:0] exp_an;
        logic [6:0] exp_sg;
        d = 32'h0123_4567;
        acks = 0;
        u_if.digit_en = 8'hFF; u_if.load = 1'b1;
        @(negedge clk);
        u_if.load = 1'b0;
        wait_fs8(ok);
        tests++; if (!ok) begin fails++; $display("FAIL pending_wait timeout"); end
        tests++; if (u_if.load_ack !== 1'b1) begin fails++; $display("FAIL pending_setup_ack got %b exp 1", u_if.load_ack); end
        // Frame with two loads landing mid-frame: must still show the old data
        for (int off = 0; off < 48; off++) begin
            int k;
            k = off / 6;
            exp_an = 8'hFF; exp_sg = 7'h7F;
            if ((off % 6) < 4) begin
                exp_an[k] = 1'b0;
                exp_sg = hex_tab[d[k*4 +: 4]];
            end
            tests++; if (u_if.anode !== exp_an) begin fails++; $display("FAIL pending_old_anode off=%0d got %h exp %h", off, u_if.anode, exp_an); end
            tests++; if (segs8 !== exp_sg) begin fails++; $display("FAIL pending_old_segs off=%0d got %b exp %b", off, segs8, exp_sg); end
            if ((off != 0) && (u_if.load_ack === 1'b1)) acks++;
            if (off == 18) begin
                u_if.data_in = 32'hFFFF_FFFF; u_if.load = 1'b1;
            end else if (off == 30) begin
                u_if.data_in = 32'h8888_8888; u_if.load = 1'b1;
            end else begin
                u_if.load = 1'b0;
            end
            @(negedge clk);
        end
        u_if.load = 1'b0;
        tests++; if (u_if.load_ack !== 1'b1) begin fails++; $display("FAIL pending_apply_ack got %b exp 1", u_if.load_ack); end
        for (int off = 0; off < 48; off++) begin
            int k;
            k = off / 6;
            exp_an = 8'hFF; exp_sg = 7'h7F;
            if ((off % 6) < 4) begin
                exp_an[k] = 1'b0;
                exp_sg = 7'b0000000;
            end
            tests++; if (u_if.anode !== exp_an) begin fails++; $display("FAIL pending_new_anode off=%0d got %h exp %h", off, u_if.anode, exp_an); end
            tests++; if (segs8 !== exp_sg) begin fails++; $display("FAIL pending_new_segs off=%0d got %b exp %b", off, segs8, exp_sg); end
            if (u_if.load_ack === 1'b1) acks++;
            @(negedge clk);
        end
        tests++; if (acks != 1) begin fails++; $display("FAIL pending_ack_count got %0d exp 1", acks); end
    endtask

    task automatic test_reset_mid();
        tests++; if (u_if.anode !== 8'hFE) begin fails++; $display("FAIL reset_mid_pre_anode got %h exp fe", u_if.anode); end
        u_if.data_in = 32'h1111_1111; u_if.load = 1'b1;
        @(negedge clk);
        u_if.load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++; if (u_if.anode !== 8'hFF) begin fails++; $display("FAIL reset_mid_anode got %h exp ff", u_if.anode); end
        tests++; if (segs8 !== 7'h7F) begin fails++; $display("FAIL reset_mid_segs got %b exp 1111111", segs8); end
        tests++; if (u_if.dp !== 1'b1) begin fails++; $display("FAIL reset_mid_dp got %b exp 1", u_if.dp); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests++; if (u_if.frame_start !== 1'b0) begin fails++; $display("FAIL reset_mid_blank_fs got %b exp 0", u_if.frame_start); end
        @(negedge clk);
        tests++; if (u_if.frame_start !== 1'b1) begin fails++; $display("FAIL reset_mid_fs got %b exp 1", u_if.frame_start); end
        tests++; if (u_if.anode !== 8'hFF) begin fails++; $display("FAIL reset_mid_dark got %h exp ff", u_if.anode); end
        tests++; if (u_if.load_ack !== 1'b0) begin fails++; $display("FAIL reset_mid_pending_lost got %b exp 0", u_if.load_ack); end
    endtask

    task automatic test_num4();
        bit ok;
        logic [31:0] d;
        logic [7:0] exp_an;
        logic [6:0] exp_sg;
        logic exp_dp;
        d = 32'h0000_9AC5;
        wait_fs4(ok);
        tests++; if (!ok) begin fails++; $display("FAIL num4_wait0 timeout"); end
        u_if4.data_in = d; u_if4.dp_in = 8'h04; u_if4.digit_en = 8'hFF; u_if4.load = 1'b1;
        @(negedge clk);
        u_if4.load = 1'b0;
        wait_fs4(ok);
        tests++; if (!ok) begin fails++; $display("FAIL num4_wait1 timeout"); end
        tests++; if (u_if4.load_ack !== 1'b1) begin fails++; $display("FAIL num4_ack got %b exp 1", u_if4.load_ack); end
        for (int off = 0; off < 24; off++) begin
            int k;
            k = off / 6;
            exp_an = 8'hFF; exp_sg = 7'h7F; exp_dp = 1'b1;
            if ((off % 6) < 4) begin
                exp_an[k] = 1'b0;
                exp_sg = hex_tab[d[k*4 +: 4]];
                exp_dp = (k == 2) ? 1'b0 : 1'b1;
            end
            tests++; if (u_if4.anode !== exp_an) begin fails++; $display("FAIL num4_anode off=%0d got %h exp %h", off, u_if4.anode, exp_an); end
            tests++; if (segs4 !== exp_sg) begin fails++; $display("FAIL num4_segs off=%0d got %b exp %b", off, segs4, exp_sg); end
            tests++; if (u_if4.dp !== exp_dp) begin fails++; $display("FAIL num4_dp off=%0d got %b exp %b", off, u_if4.dp, exp_dp); end
            tests++; if (u_if4.frame_start !== (off == 0)) begin fails++; $display("FAIL num4_fs off=%0d got %b exp %b", off, u_if4.frame_start, (off == 0)); end
            @(negedge clk);
        end
        tests++; if (u_if4.frame_start !== 1'b1) begin fails++; $display("FAIL num4_period got %b exp 1", u_if4.frame_start); end
        tests++; if (u_if4.anode !== 8'hFE) begin fails++; $display("FAIL num4_wrap_anode got %h exp fe", u_if4.anode); end
    endtask

    initial begin
        test_reset();
        test_post_reset();
        test_load_basic();
        test_timing();
        test_enable();
        test_pending();
        test_reset_mid();
        test_num4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
